// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: requester IDs, FSM states and
// the packed load/store request bundle.
package data_mem_arbiter_pkg;

    // Requester IDs are sized for the largest supported requester count, so
    // one ID type serves every legal NUM_REQ (2..4).
    localparam int NUM_REQ_MAX = 4;
    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;

    // $clog2 with a floor of 1, so a single requester still gets a 1-bit ID.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One requester's address-phase payload.
    typedef struct packed {
        logic                    we;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W/8-1:0] be;
        logic [MEM_DATA_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs. Each ID is pushed when its address phase is
// accepted and popped when its response returns. DEPTH must be a power of 2
// (at least 2), so the pointers wrap on their own.
module data_mem_arbiter_id_fifo
    import data_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  req_id_t i_push_id,
    input  logic    i_pop,
    output req_id_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit lets the counter tell full from empty.
    localparam int CNT_W = $clog2(DEPTH) + 1;

    req_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy update. A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory port between NUM_REQ
// load/store requesters. The address phase locks once it has been presented,
// and responses are routed back in issue order through an ID FIFO.
// Optional feature, DATA_MEM_ARBITER_ERR_EN: adds the err_o/err_cnt_o
// outputs, which flag and count responses that arrive when no ID is outstanding.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] be_i,
    input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          data_req_o,
    output logic                          data_we_o,
    output logic [ADDR_W-1:0]             data_addr_o,
    output logic [DATA_W/8-1:0]           data_be_o,
    output logic [DATA_W-1:0]             data_wdata_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    input  logic [DATA_W-1:0]             data_rdata_i
`ifdef DATA_MEM_ARBITER_ERR_EN
    ,
    output logic                          err_o,
    output logic [7:0]                    err_cnt_o
`endif
);

    localparam int BE_W = DATA_W / 8;

    state_e  r_state;
    req_id_t r_rr_ptr;
    req_id_t r_sel;

    logic    w_found;
    req_id_t w_pick;
    req_id_t w_cur_sel;
    logic    w_cur_req;
    logic    w_accept;
    logic    w_pop;
    logic    w_fifo_full;
    logic    w_fifo_empty;
    req_id_t w_head;

    // Round-robin search: the first active requester at or after the pointer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req_i[j] && (j == (int'(r_rr_ptr) + k) % NUM_REQ)) begin
                    w_found = 1'b1;
                    w_pick  = req_id_t'(j);
                end
            end
        end
    end

    // In HOLD the registered selection is kept, even if its request drops.
    always_comb begin
        w_cur_sel = (r_state == HOLD) ? r_sel : w_pick;
        w_cur_req = (r_state == HOLD) || w_found;
    end

    // Issue is gated by reset and by a full ID FIFO. A pop in the same cycle does not lift the full gate.
    assign data_req_o = rst_n && w_cur_req && !w_fifo_full;
    assign w_accept   = data_req_o && data_gnt_i;
    assign w_pop      = rst_n && data_rvalid_i && !w_fifo_empty;
    assign rdata_o    = data_rdata_i;

    // Drive the memory-side payload from the selected requester.
    always_comb begin
        data_we_o    = 1'b0;
        data_addr_o  = '0;
        data_be_o    = '0;
        data_wdata_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_cur_sel == req_id_t'(j)) begin
                data_we_o    = we_i[j];
                data_addr_o  = addr_i[j*ADDR_W +: ADDR_W];
                data_be_o    = be_i[j*BE_W +: BE_W];
                data_wdata_o = wdata_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot grant to the accepted requester and response to the FIFO head.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_o[j]    = w_accept && (w_cur_sel == req_id_t'(j));
            rvalid_o[j] = w_pop && (w_head == req_id_t'(j));
        end
    end

    // Arbitration FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_sel    <= '0;
        end else begin
            if (w_accept) r_rr_ptr <= req_id_t'((int'(w_cur_sel) + 1) % NUM_REQ);
            case (r_state)
                IDLE: begin
                    if (data_req_o && !data_gnt_i) begin
                        r_state <= HOLD;
                        r_sel   <= w_pick;
                    end
                end
                HOLD: begin
                    if (w_accept) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    data_mem_arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_push_id (w_cur_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

`ifdef DATA_MEM_ARBITER_ERR_EN
    logic       r_err;
    logic [7:0] r_err_cnt;

    // Sticky flag and saturating count of responses that arrive with no ID outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (data_rvalid_i && w_fifo_empty) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
// A queue-based reference model is compared against the DUT on every falling
// edge. The directed scenarios also carry hand-computed literal expectations.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i, we_i, gnt_o, rvalid_o;
    logic [N*AW-1:0] addr_i;
    logic [N*BW-1:0] be_i;
    logic [N*DW-1:0] wdata_i;
    logic [DW-1:0]   rdata_o, data_wdata_o, data_rdata_i;
    logic            data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
    logic [AW-1:0]   data_addr_o;
    logic [BW-1:0]   data_be_o;
`ifdef DATA_MEM_ARBITER_ERR_EN
    logic            err_o;
    logic [7:0]      err_cnt_o;
`endif

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
`ifdef DATA_MEM_ARBITER_ERR_EN
        , .err_o(err_o), .err_cnt_o(err_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    mem_req_t pay [N];

    // Reference model state: outstanding IDs in issue order, RR pointer, locked requester.
    int q[$];
    int m_rr   = 0;
    int m_lock = -1;
    int m_err  = 0;
    int m_cnt  = 0;

    always @(negedge clk) begin : model
        int           sel;
        bit           act, ereq, acc, pop;
        logic [N-1:0] eg, er;
        sel = 0; act = 0; eg = '0; er = '0;
        if (!rst_n) begin
            check("rst_data_req", 64'(data_req_o), 64'(0));
            check("rst_gnt", 64'(gnt_o), 64'(0));
            check("rst_rvalid", 64'(rvalid_o), 64'(0));
            q.delete();
            m_rr = 0; m_lock = -1; m_err = 0; m_cnt = 0;
        end else begin
            if (m_lock >= 0) begin
                sel = m_lock; act = 1;
            end else begin
                for (int k = 0; k < N; k++)
                    if (!act && req_i[(m_rr + k) % N]) begin
                        act = 1; sel = (m_rr + k) % N;
                    end
            end
            ereq = act && (q.size() < MAXO);
            acc  = ereq && data_gnt_i;
            pop  = data_rvalid_i && (q.size() > 0);
            if (acc) eg[sel] = 1'b1;
            if (pop) er[q[0]] = 1'b1;
            check("m_data_req", 64'(data_req_o), 64'(ereq));
            check("m_gnt", 64'(gnt_o), 64'(eg));
            check("m_rvalid", 64'(rvalid_o), 64'(er));
            if (ereq) begin
                check("m_we", 64'(data_we_o), 64'(pay[sel].we));
                check("m_addr", 64'(data_addr_o), 64'(pay[sel].addr));
                check("m_be", 64'(data_be_o), 64'(pay[sel].be));
                check("m_wdata", 64'(data_wdata_o), 64'(pay[sel].wdata));
            end
            if (pop) check("m_rdata", 64'(rdata_o), 64'(data_rdata_i));
`ifdef DATA_MEM_ARBITER_ERR_EN
            check("m_err", 64'(err_o), 64'(m_err));
            check("m_err_cnt", 64'(err_cnt_o), 64'(m_cnt));
`endif
            if (data_rvalid_i && q.size() == 0) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(sel);
                m_rr   = (sel + 1) % N;
                m_lock = -1;
            end else if (ereq) begin
                m_lock = sel;
            end
        end
    end

    // Applies one cycle of stimulus after the rising edge, then returns just after the falling edge.
    task automatic drive(input logic rst, input logic [N-1:0] req, input logic gnt,
                         input logic rv, input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        rst_n         = rst;
        req_i         = req;
        data_gnt_i    = gnt;
        data_rvalid_i = rv;
        data_rdata_i  = rd;
        for (int r = 0; r < N; r++) begin
            we_i[r]                = pay[r].we;
            addr_i[r*AW +: AW]     = pay[r].addr;
            be_i[r*BW +: BW]       = pay[r].be;
            wdata_i[r*DW +: DW]    = pay[r].wdata;
        end
        @(negedge clk);
        #1;
    endtask

    // Drains outstanding responses and checks the routing order.
    task automatic drain(input logic [N-1:0] exp0, input logic [N-1:0] exp1,
                         input logic [N-1:0] exp2, input logic [N-1:0] exp3, input int n);
        logic [N-1:0] exp [4];
        exp[0] = exp0; exp[1] = exp1; exp[2] = exp2; exp[3] = exp3;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
            check("drain_rvalid", 64'(rvalid_o), 64'(exp[i]));
        end
    endtask

    initial begin
        logic [N-1:0] g_exp [4];
        logic [N-1:0] r_exp [4];
        rst_n = 1'b0; req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        pay[0] = '{we: 1'b1, addr: 32'h0000_0100, be: 4'hF, wdata: 32'hDEAD_BEEF};
        pay[1] = '{we: 1'b0, addr: 32'h0000_0180, be: 4'h3, wdata: 32'h1111_2222};

        // Reset with activity on every input: the bus and the requester side stay quiet.
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'hBAD0_0000);
        check("reset_data_req", 64'(data_req_o), 64'(0));
        check("reset_gnt", 64'(gnt_o), 64'(0));
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'hBAD0_0001);
        check("reset_rvalid", 64'(rvalid_o), 64'(0));

        // Single store from requester 0: granted in the same cycle, response two cycles later.
        drive(1'b1, 2'b01, 1'b1, 1'b0, '0);
        check("store_gnt", 64'(gnt_o), 64'(2'b01));
        check("store_addr", 64'(data_addr_o), 64'(32'h100));
        check("store_wdata", 64'(data_wdata_o), 64'(32'hDEAD_BEEF));
        check("store_be", 64'(data_be_o), 64'(4'hF));
        check("store_we", 64'(data_we_o), 64'(1));
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
        drive(1'b1, 2'b00, 1'b0, 1'b1, 32'hC0FF_EE00);
        check("store_rvalid", 64'(rvalid_o), 64'(2'b01));
        check("store_rdata", 64'(rdata_o), 64'(32'hC0FF_EE00));

        // Both requesters load continuously. The pointer starts at 1, so grants alternate 10,01,10,01.
        pay[0] = '{we: 1'b0, addr: 32'h0000_0104, be: 4'hF, wdata: 32'h0};
        pay[1] = '{we: 1'b0, addr: 32'h0000_0204, be: 4'hF, wdata: 32'h0};
        g_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
        r_exp = '{2'b00, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 1'b1, (i > 0), 32'hB000_0000 + 32'(i));
            check("alt_gnt", 64'(gnt_o), 64'(g_exp[i]));
            check("alt_rvalid", 64'(rvalid_o), 64'(r_exp[i]));
        end
        drain(2'b01, 2'b00, 2'b00, 2'b00, 1);

        // Stall: requester 0 is held three cycles and requester 1 cannot preempt it.
        pay[0].addr = 32'h0000_0200;
        pay[1].addr = 32'h0000_0300;
        drive(1'b1, 2'b01, 1'b0, 1'b0, '0);
        check("stall_addr0", 64'(data_addr_o), 64'(32'h200));
        check("stall_gnt0", 64'(gnt_o), 64'(0));
        drive(1'b1, 2'b11, 1'b0, 1'b0, '0);
        check("stall_addr1", 64'(data_addr_o), 64'(32'h200));
        drive(1'b1, 2'b11, 1'b0, 1'b0, '0);
        check("stall_addr2", 64'(data_addr_o), 64'(32'h200));
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("stall_gnt_r0", 64'(gnt_o), 64'(2'b01));
        drive(1'b1, 2'b10, 1'b1, 1'b0, '0);
        check("stall_gnt_r1", 64'(gnt_o), 64'(2'b10));
        check("stall_addr_r1", 64'(data_addr_o), 64'(32'h300));
        drain(2'b01, 2'b10, 2'b00, 2'b00, 2);

        // Four accepted loads fill the FIFO, so issue stays blocked through the pop cycle.
        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
            check("fill_gnt", 64'(gnt_o), 64'(g_exp[i]));
        end
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("full_data_req", 64'(data_req_o), 64'(0));
        check("full_gnt", 64'(gnt_o), 64'(0));
        drive(1'b1, 2'b11, 1'b1, 1'b1, 32'hD000_0001);
        check("full_pop_data_req", 64'(data_req_o), 64'(0));
        check("full_pop_rvalid", 64'(rvalid_o), 64'(2'b01));
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("resume_data_req", 64'(data_req_o), 64'(1));
        check("resume_gnt", 64'(gnt_o), 64'(2'b01));
        drain(2'b10, 2'b01, 2'b10, 2'b01, 4);

        // Accept and response in the same cycle at occupancy 2: the old head is routed and occupancy stays 2.
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("sim_gnt_a", 64'(gnt_o), 64'(2'b10));
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("sim_gnt_b", 64'(gnt_o), 64'(2'b01));
        drive(1'b1, 2'b10, 1'b1, 1'b1, 32'hE000_0002);
        check("sim_gnt", 64'(gnt_o), 64'(2'b10));
        check("sim_rvalid_old_head", 64'(rvalid_o), 64'(2'b10));
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0);
        check("sim_full_after_2", 64'(data_req_o), 64'(0));
        drain(2'b01, 2'b10, 2'b01, 2'b10, 4);

        // Reset with three outstanding IDs, then a response arrives that no ID expects.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b1, 1'b0, '0);
            check("pre_rst_gnt", 64'(gnt_o), 64'(2'b01));
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0);
        drive(1'b1, 2'b00, 1'b0, 1'b1, 32'hF000_0003);
        check("post_rst_rvalid", 64'(rvalid_o), 64'(0));
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
`ifdef DATA_MEM_ARBITER_ERR_EN
        check("err_set", 64'(err_o), 64'(1));
        check("err_cnt_1", 64'(err_cnt_o), 64'(1));
`endif
        drive(1'b1, 2'b10, 1'b1, 1'b0, '0);
        check("post_rst_gnt", 64'(gnt_o), 64'(2'b10));
        drain(2'b10, 2'b00, 2'b00, 2'b00, 1);
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
